hazard_unit_param: RTL

- Parametrised successor to the core's fixed five-register hazard controller.
- Takes per-stage busy flags and up to N_REDIRECT PC-redirect sources; drives stall/flush for every pipeline register and the fetch PC load.
- Adds what the fixed version lacks: latched pending redirects that survive downstream freezes, priority among multiple redirect stages, a stall watchdog, and optional saturating hazard counters.

---
 rtl/hazard_unit_param_pkg.sv | 11 +
 rtl/hazard_unit_param_perf_counter.sv | 16 +
 rtl/hazard_unit_param.sv | 93 +++++++++
 3 files changed

// File: rtl/hazard_unit_param_pkg.sv
// hazard_unit_param_pkg: shared pipeline stage indices and redirect source ids
package hazard_unit_param_pkg;
  localparam int STG_IF  = 0;
  localparam int STG_DEC = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  typedef enum logic [0:0] {
    REDIR_DEC = 1'b0,
    REDIR_EX  = 1'b1
  } redir_src_e;
endpackage

// File: rtl/hazard_unit_param_perf_counter.sv
// hazard_perf_counter: single saturating event counter
module hazard_perf_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);
  logic [CNT_WIDTH-1:0] cnt_q;
  // count events, holding at all-ones
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (inc_i && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_unit_param.sv
// hazard_unit_param: stall/flush/redirect control with pending redirects and watchdog; HAZARD_PERF_CNT_EN adds perf counters
module hazard_unit_param
  import hazard_unit_param_pkg::*;
#(
  parameter int N_STAGES   = 4,
  parameter int N_REDIRECT = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int WDOG_LIMIT = 1024,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_STAGES-1:0]              busy_i,
  input  logic [N_REDIRECT-1:0]            redir_valid_i,
  input  logic [N_REDIRECT*ADDR_WIDTH-1:0] redir_pc_i,
  output logic [N_STAGES:0]                stall_o,
  output logic [N_STAGES:0]                flush_o,
  output logic                             load_pc_we_o,
  output logic [ADDR_WIDTH-1:0]            load_pc_o,
  output logic                             wdog_trip_o,
  output logic [N_STAGES*CNT_WIDTH-1:0]    perf_busy_o,
  output logic [N_REDIRECT*CNT_WIDTH-1:0]  perf_redir_o
);
  localparam int WW = $clog2(WDOG_LIMIT + 1);
  logic [N_REDIRECT-1:0] pend_q, pend_d, pv, fire_oh, clr;
  logic [ADDR_WIDTH-1:0] pc_q [N_REDIRECT];
  logic [ADDR_WIDTH-1:0] pc_d [N_REDIRECT];
  logic [N_STAGES:0]     stall, flush;
  logic [ADDR_WIDTH-1:0] load_pc;
  logic                  fire, trip_q, trip_d;
  logic [WW-1:0]         wcnt_q, wcnt_d;
  // pick the deepest unfrozen pending redirect (new pulses bypass the pending regs), then derive stall/flush/watchdog
  always_comb begin
    fire_oh = '0;
    load_pc = '0;
    for (int r = 0; r < N_REDIRECT; r++) begin
      pv[r]   = pend_q[r] | redir_valid_i[r];
      pc_d[r] = redir_valid_i[r] ? redir_pc_i[r*ADDR_WIDTH +: ADDR_WIDTH] : pc_q[r];
      if (pv[r] && !(|(busy_i >> (r + 1)))) begin
        fire_oh    = '0;
        fire_oh[r] = 1'b1;
        load_pc    = pc_d[r];
      end
    end
    fire = |fire_oh;
    for (int r = 0; r < N_REDIRECT; r++) clr[r] = |(fire_oh >> r);
    pend_d = pv & ~clr;
    stall[N_STAGES] = 1'b0;
    flush[0] = 1'b0;
    for (int j = 0; j < N_STAGES; j++) begin
      stall[j]   = |(busy_i >> j);
      flush[j+1] = busy_i[j] | (|(fire_oh >> j));
    end
    if (fire) stall[STG_IF] = 1'b0;
    wcnt_d = (stall[STG_IF] && !fire) ? ((wcnt_q == WW'(WDOG_LIMIT)) ? wcnt_q : wcnt_q + 1'b1) : '0;
    trip_d = trip_q | (wcnt_d == WW'(WDOG_LIMIT));
  end
  // pending redirect and watchdog state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend_q <= '0;
      for (int r = 0; r < N_REDIRECT; r++) pc_q[r] <= '0;
      wcnt_q <= '0;
      trip_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      for (int r = 0; r < N_REDIRECT; r++) pc_q[r] <= pc_d[r];
      wcnt_q <= wcnt_d;
      trip_q <= trip_d;
    end
  assign stall_o      = stall;
  assign flush_o      = flush;
  assign load_pc_we_o = fire;
  assign load_pc_o    = load_pc;
  assign wdog_trip_o  = trip_q;
`ifdef HAZARD_PERF_CNT_EN
  for (genvar g = 0; g < N_STAGES; g++) begin : g_busy
    hazard_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk(clk), .rst_n(rst_n), .inc_i(busy_i[g]),
      .cnt_o(perf_busy_o[g*CNT_WIDTH +: CNT_WIDTH])
    );
  end
  for (genvar g = 0; g < N_REDIRECT; g++) begin : g_redir
    hazard_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk(clk), .rst_n(rst_n), .inc_i(fire_oh[g]),
      .cnt_o(perf_redir_o[g*CNT_WIDTH +: CNT_WIDTH])
    );
  end
`else
  assign perf_busy_o  = '0;
  assign perf_redir_o = '0;
`endif
endmodule
